// File: rtl/sdram_arbit_if.sv
// Bundle of requester-side and SDRAM-side signals around the SDRAM command arbiter.
// The arbiter takes the slave view. The requesters, or a bench, take the master view.
interface sdram_arbit_if;
   logic        init_end;
   logic [3:0]  init_cmd;
   logic [12:0] init_addr;

   logic        ref_req;
   logic        ref_end;
   logic [3:0]  ref_cmd;
   logic [12:0] ref_addr;

   logic        wr_req;
   logic        wr_end;
   logic [3:0]  wr_cmd;
   logic [12:0] wr_addr;
   logic [1:0]  wr_ba;

   logic        rd_req;
   logic        rd_end;
   logic [3:0]  rd_cmd;
   logic [12:0] rd_addr;
   logic [1:0]  rd_ba;

   logic        ref_en;
   logic        wr_en;
   logic        rd_en;
   logic        ref_pend;

   logic        sdram_cke;
   logic [3:0]  sdram_cmd;
   logic [12:0] sdram_addr;
   logic [1:0]  sdram_ba;

   modport slave (
      input  init_end, init_cmd, init_addr,
      input  ref_req, ref_end, ref_cmd, ref_addr,
      input  wr_req, wr_end, wr_cmd, wr_addr, wr_ba,
      input  rd_req, rd_end, rd_cmd, rd_addr, rd_ba,
      output ref_en, wr_en, rd_en, ref_pend,
      output sdram_cke, sdram_cmd, sdram_addr, sdram_ba
   );

   modport master (
      output init_end, init_cmd, init_addr,
      output ref_req, ref_end, ref_cmd, ref_addr,
      output wr_req, wr_end, wr_cmd, wr_addr, wr_ba,
      output rd_req, rd_end, rd_cmd, rd_addr, rd_ba,
      input  ref_en, wr_en, rd_en, ref_pend,
      input  sdram_cke, sdram_cmd, sdram_addr, sdram_ba
   );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter. It grants the bus to the init, refresh, write or read engine.
// Refresh has the highest priority. Write and read alternate when they contend.
module sdram_arbit #(
   parameter logic [3:0] CMD_NOP = 4'b0111
) (
   input  logic         sclk,
   input  logic         s_rst,
   sdram_arbit_if.slave bus
);

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      IDLE  = 3'd1,
      AREF  = 3'd2,
      WRITE = 3'd3,
      READ  = 3'd4
   } state_t;

   state_t state, next_state;
   logic   last_wr;
   logic   ref_en_q, wr_en_q, rd_en_q, ref_pend_q;

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) state <= INIT;
      else       state <= next_state;
   end

   // IDLE is always visited between two grants, so each grant is separated by at least one NOP.
   always_comb begin
      next_state = state;
      case (state)
         INIT:  if (bus.init_end) next_state = IDLE;
         IDLE: begin
            if (bus.ref_req)                    next_state = AREF;
            else if (bus.wr_req && bus.rd_req) next_state = last_wr ? READ : WRITE;
            else if (bus.wr_req)               next_state = WRITE;
            else if (bus.rd_req)               next_state = READ;
         end
         AREF:  if (bus.ref_end) next_state = IDLE;
         WRITE: if (bus.wr_end)  next_state = IDLE;
         READ:  if (bus.rd_end)  next_state = IDLE;
         default: next_state = INIT;
      endcase
   end

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         last_wr <= 1'b0;
      end else if (state == IDLE) begin
         if (next_state == WRITE)     last_wr <= 1'b1;
         else if (next_state == READ) last_wr <= 1'b0;
      end
   end

   // Grant and pending flags are built from next_state.
   // After each edge they therefore track the current state exactly.
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         ref_en_q   <= 1'b0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         ref_pend_q <= 1'b0;
      end else begin
         ref_en_q   <= (next_state == AREF);
         wr_en_q    <= (next_state == WRITE);
         rd_en_q    <= (next_state == READ);
         ref_pend_q <= bus.ref_req && ((next_state == WRITE) || (next_state == READ));
      end
   end

   assign bus.ref_en    = ref_en_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.ref_pend  = ref_pend_q;
   assign bus.sdram_cke = 1'b1;

   always_comb begin
      bus.sdram_cmd  = CMD_NOP;
      bus.sdram_addr = 13'd0;
      bus.sdram_ba   = 2'b00;
      case (state)
         INIT: begin
            bus.sdram_cmd  = bus.init_cmd;
            bus.sdram_addr = bus.init_addr;
         end
         AREF: begin
            bus.sdram_cmd  = bus.ref_cmd;
            bus.sdram_addr = bus.ref_addr;
         end
         WRITE: begin
            bus.sdram_cmd  = bus.wr_cmd;
            bus.sdram_addr = bus.wr_addr;
            bus.sdram_ba   = bus.wr_ba;
         end
         READ: begin
            bus.sdram_cmd  = bus.rd_cmd;
            bus.sdram_addr = bus.rd_addr;
            bus.sdram_ba   = bus.rd_ba;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit.
// It covers reset and init hold, priority, write/read alternation, ref_pend, ignored end pulses and async abort.
module tb_sdram_arbit;

   localparam logic [3:0] NOP = 4'b0111;

   logic sclk;
   logic s_rst;
   int   n_cmp;
   int   n_err;

   sdram_arbit_if bus ();

   sdram_arbit #(.CMD_NOP(NOP)) dut (
      .sclk (sclk),
      .s_rst(s_rst),
      .bus  (bus)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_en(input string tag, input logic r, input logic w, input logic d);
      chk({tag, ".ref_en"}, {15'd0, bus.ref_en}, {15'd0, r});
      chk({tag, ".wr_en"},  {15'd0, bus.wr_en},  {15'd0, w});
      chk({tag, ".rd_en"},  {15'd0, bus.rd_en},  {15'd0, d});
   endtask

   task automatic chk_bus(input string tag, input logic [3:0] c, input logic [12:0] a, input logic [1:0] b);
      chk({tag, ".cmd"},  {12'd0, bus.sdram_cmd}, {12'd0, c});
      chk({tag, ".addr"}, {3'd0, bus.sdram_addr}, {3'd0, a});
      chk({tag, ".ba"},   {14'd0, bus.sdram_ba},  {14'd0, b});
   endtask

   // The bench is one edge after the grant when this is called. It holds the burst for 10 cycles, then ends it.
   task automatic serve(input string tag, input logic is_wr, input logic poke_rd_end);
      chk_en({tag, ".grant"}, 1'b0, is_wr, !is_wr);
      if (is_wr) chk_bus({tag, ".bus"}, 4'h3, 13'h0333, 2'b01);
      else       chk_bus({tag, ".bus"}, 4'h4, 13'h0444, 2'b10);
      chk({tag, ".pend"}, {15'd0, bus.ref_pend}, 16'd0);
      for (int i = 0; i < 9; i++) begin
         if (poke_rd_end && i == 3) bus.rd_end = 1'b1;
         tick();
         bus.rd_end = 1'b0;
         chk_en({tag, ".hold"}, 1'b0, is_wr, !is_wr);
      end
      if (is_wr) bus.wr_end = 1'b1;
      else       bus.rd_end = 1'b1;
      tick();
      bus.wr_end = 1'b0;
      bus.rd_end = 1'b0;
      chk_en({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
      chk_bus({tag, ".idle"}, NOP, 13'd0, 2'b00);
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      s_rst = 1'b1;
      bus.init_end  = 1'b0; bus.init_cmd = 4'h1; bus.init_addr = 13'h0111;
      bus.ref_req   = 1'b0; bus.ref_end  = 1'b0; bus.ref_cmd   = 4'h2; bus.ref_addr = 13'h0222;
      bus.wr_req    = 1'b0; bus.wr_end   = 1'b0; bus.wr_cmd    = 4'h3; bus.wr_addr  = 13'h0333;
      bus.wr_ba     = 2'b01;
      bus.rd_req    = 1'b0; bus.rd_end   = 1'b0; bus.rd_cmd    = 4'h4; bus.rd_addr  = 13'h0444;
      bus.rd_ba     = 2'b10;
      tick();
      tick();

      // Reset state
      chk_en("rst", 1'b0, 1'b0, 1'b0);
      chk("rst.pend", {15'd0, bus.ref_pend}, 16'd0);
      chk("rst.cke", {15'd0, bus.sdram_cke}, 16'd1);
      chk_bus("rst", 4'h1, 13'h0111, 2'b00);

      // INIT ignores requests and mirrors the init command bus
      s_rst = 1'b0;
      bus.wr_req = 1'b1;
      for (int i = 0; i < 100; i++) begin
         bus.init_cmd  = 4'(i);
         bus.init_addr = 13'(i * 37);
         tick();
         chk("init.wr_en", {15'd0, bus.wr_en}, 16'd0);
         chk("init.cmd", {12'd0, bus.sdram_cmd}, {12'd0, 4'(i)});
         chk("init.addr", {3'd0, bus.sdram_addr}, {3'd0, 13'(i * 37)});
      end
      chk("init.cke", {15'd0, bus.sdram_cke}, 16'd1);

      // All requests arrive together with init_end. Refresh wins, and its grant appears two edges later.
      bus.init_end = 1'b1;
      bus.ref_req  = 1'b1;
      bus.rd_req   = 1'b1;
      tick();
      chk_en("idle1", 1'b0, 1'b0, 1'b0);
      chk_bus("idle1", NOP, 13'd0, 2'b00);
      tick();
      chk_en("aref", 1'b1, 1'b0, 1'b0);
      chk_bus("aref", 4'h2, 13'h0222, 2'b00);
      bus.init_end = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_en("aref.hold", 1'b1, 1'b0, 1'b0);
      end
      bus.ref_end = 1'b1;
      bus.ref_req = 1'b0;
      tick();
      bus.ref_end = 1'b0;
      chk_en("aref.exit", 1'b0, 1'b0, 1'b0);
      chk_bus("aref.exit", NOP, 13'd0, 2'b00);
      tick();

      // Contended write and read requests alternate, starting with write. A stray rd_end during WRITE is ignored.
      serve("alt1.wr", 1'b1, 1'b1);
      serve("alt2.rd", 1'b0, 1'b0);
      serve("alt3.wr", 1'b1, 1'b0);
      serve("alt4.rd", 1'b0, 1'b0);

      // A refresh request during WRITE sets ref_pend. The burst ends, IDLE follows, then AREF runs.
      bus.rd_req = 1'b0;
      chk_en("w.grant", 1'b0, 1'b1, 1'b0);
      tick();
      bus.ref_req = 1'b1;
      tick();
      chk("w.pend", {15'd0, bus.ref_pend}, 16'd1);
      chk_en("w.pendhold", 1'b0, 1'b1, 1'b0);
      bus.wr_end = 1'b1;
      bus.wr_req = 1'b0;
      tick();
      bus.wr_end = 1'b0;
      chk_en("w.idle", 1'b0, 1'b0, 1'b0);
      tick();
      chk_en("w.aref", 1'b1, 1'b0, 1'b0);
      chk("w.aref.pend", {15'd0, bus.ref_pend}, 16'd0);
      bus.ref_req = 1'b0;
      bus.ref_end = 1'b1;
      tick();
      bus.ref_end = 1'b0;
      chk_en("w.aref.exit", 1'b0, 1'b0, 1'b0);

      // An end pulse arriving while IDLE has no effect
      bus.wr_end = 1'b1;
      tick();
      bus.wr_end = 1'b0;
      chk_en("idle.end", 1'b0, 1'b0, 1'b0);

      // Asserting reset in the middle of a READ aborts it immediately
      bus.rd_req = 1'b1;
      tick();
      chk_en("r.grant", 1'b0, 1'b0, 1'b1);
      chk_bus("r.grant", 4'h4, 13'h0444, 2'b10);
      tick();
      bus.init_cmd  = 4'hA;
      bus.init_addr = 13'h0ABC;
      #2;
      s_rst = 1'b1;
      #1;
      chk_en("r.abort", 1'b0, 1'b0, 1'b0);
      chk_bus("r.abort", 4'hA, 13'h0ABC, 2'b00);
      chk("r.abort.cke", {15'd0, bus.sdram_cke}, 16'd1);
      tick();
      chk_en("r.abort.hold", 1'b0, 1'b0, 1'b0);

      // Re-initialise. Write must win the first contention again.
      @(posedge sclk);
      #1;
      s_rst = 1'b0;
      bus.init_end = 1'b1;
      bus.wr_req   = 1'b1;
      tick();
      chk_bus("reinit.idle", NOP, 13'd0, 2'b00);
      tick();
      chk_en("reinit.grant", 1'b0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout compared=%0d mismatched=%0d", n_cmp, n_err);
      $fatal(1, "bench did not finish");
   end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have parameter CMD_NOP, default 4'b0111, meaning NOP encoding {cs_n,ras_n,cas_n,we_n} driven when no requester is granted.
REQ-002 SHALL have port sclk, input, 1, system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port s_rst, input, 1, reset; it is asynchronous and active-high.
REQ-004 SHALL have ports init_end (in, 1), init_cmd (in, 4) and init_addr (in, 13), meaning init sequencer done flag, command and address.
REQ-005 SHALL have ports ref_req (in, 1), ref_end (in, 1), ref_cmd (in, 4) and ref_addr (in, 13), meaning auto-refresh requester request, done pulse, command and address.
REQ-006 SHALL have ports wr_req (in, 1), wr_end (in, 1), wr_cmd (in, 4), wr_addr (in, 13) and wr_ba (in, 2), meaning write burst requester signals.
REQ-007 SHALL have ports rd_req (in, 1), rd_end (in, 1), rd_cmd (in, 4), rd_addr (in, 13) and rd_ba (in, 2), meaning read burst requester signals.
REQ-008 SHALL have grant outputs ref_en, wr_en and rd_en (each out, 1), each high for the whole time its requester owns the bus.
REQ-009 SHALL have output ref_pend (out, 1), meaning a refresh is waiting, so the active burst engine terminates at its next burst boundary.
REQ-010 SHALL have outputs sdram_cke (1), sdram_cmd (4), sdram_addr (13) and sdram_ba (2), meaning the SDRAM command bus.

Function
REQ-011 SHALL implement a registered FSM with states INIT, IDLE, AREF, WRITE and READ.
REQ-012 INIT SHALL go to IDLE on the first cycle init_end=1; in INIT all requests are ignored.
REQ-013 IDLE SHALL apply fixed priority, with ref_req first, then wr/rd, and SHALL go to AREF, WRITE or READ on the next edge.
REQ-014 When wr_req and rd_req are both high in IDLE (and ref_req is low), the FSM SHALL serve the one not served last, tracked by a 1-bit last_wr flag; after reset last_wr=0, so write wins first.
REQ-015 AREF, WRITE and READ SHALL return to IDLE on the edge where ref_end, wr_end or rd_end respectively is 1; end pulses in any other state SHALL be ignored.
REQ-016 After any return, IDLE SHALL last at least one cycle (NOP) before the next grant, so there are no back-to-back grants.
REQ-017 ref_en, wr_en and rd_en SHALL be registered, high exactly while state is AREF, WRITE or READ; at most one SHALL be high at a time.
REQ-018 Requesters SHALL hold req at level until granted; the arbiter SHALL not latch pulses.
REQ-019 ref_pend SHALL be registered and equal 1 when ref_req=1 and state is WRITE or READ, and 0 otherwise.
REQ-020 Command mux (combinational on state): INIT passes init_cmd/init_addr; AREF passes ref_cmd/ref_addr; WRITE passes wr_*; READ passes rd_*.
REQ-021 In INIT and AREF, sdram_ba SHALL be 2'b00.
REQ-022 In IDLE the bus SHALL drive CMD_NOP, addr 0 and ba 0.
REQ-023 sdram_cke SHALL be constant 1 after reset is released.
REQ-024 If init_end falls after INIT, the FSM SHALL remain operational; re-initialisation occurs only via s_rst.
REQ-025 If ref_end coincides with a new wr_req, the FSM SHALL go AREF->IDLE on that edge and grant the write on the following edge.

Reset
REQ-026 While s_rst=1: state=INIT, last_wr=0, ref_en=wr_en=rd_en=0, ref_pend=0, sdram_cke=1, and the command bus follows init_cmd/init_addr with ba=0.
REQ-027 Reset asserted mid-burst SHALL abort immediately and asynchronously to INIT; grants drop without waiting for *_end.

Verification
REQ-028 Reset, hold init_end=0 for 100 cycles with wr_req=1 -> no grant; sdram_cmd mirrors init_cmd; wr_en stays 0.
REQ-029 init_end=1, then ref_req=wr_req=rd_req=1 in the same cycle -> ref_en=1 two edges later; wr/rd granted only after ref_end plus one IDLE cycle.
REQ-030 wr_req=rd_req=1 held continuously, ends after 10 cycles each -> grant order WRITE, READ, WRITE, READ with a one-cycle NOP between grants.
REQ-031 In WRITE, raise ref_req -> ref_pend=1 the next cycle; on wr_end the FSM goes to IDLE, then AREF; ref_pend=0 once in AREF.
REQ-032 rd_end pulse while in WRITE -> ignored, wr_en stays 1.
REQ-033 Assert s_rst mid-READ -> rd_en=0 immediately, state=INIT, and the bus shows init_cmd.
